// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage multiply/divide request and HI/LO result bundle
interface e_mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;
    modport master (output start, mdu_op, a, b, input busy, hi, lo, mdu_out);
    modport slave  (input start, mdu_op, a, b, output busy, hi, lo, mdu_out);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning the architectural HI/LO registers
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic     clk,
    input logic     reset,
    e_mdu_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_v_q, pend_v_d;

    logic        is_mul, is_div;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_nz, bm_nz, sq, sr, uq, ur;

    assign is_mul = bus.mdu_op == 4'd1 || bus.mdu_op == 4'd2;
    assign is_div = bus.mdu_op == 4'd3 || bus.mdu_op == 4'd4;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0
    always_comb begin
        prod_s = 64'($signed(bus.a)) * 64'($signed(bus.b));
        prod_u = {32'b0, bus.a} * {32'b0, bus.b};
        a_mag  = bus.a[31] ? -bus.a : bus.a;
        b_mag  = bus.b[31] ? -bus.b : bus.b;
        b_nz   = (bus.b == 32'd0) ? 32'd1 : bus.b;
        bm_nz  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        sq     = a_mag / bm_nz;
        sr     = a_mag % bm_nz;
        uq     = bus.a / b_nz;
        ur     = bus.a % b_nz;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_v_q  <= pend_v_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_v_d  = pend_v_q;
        if (state_q == IDLE) begin
            if (bus.start && (is_mul || is_div)) begin
                state_d  = RUN;
                cnt_d    = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                pend_v_d = !(is_div && bus.b == 32'd0);
                case (bus.mdu_op)
                    4'd1:    {pend_hi_d, pend_lo_d} = prod_s;
                    4'd2:    {pend_hi_d, pend_lo_d} = prod_u;
                    4'd3: begin
                        pend_lo_d = (bus.a[31] ^ bus.b[31]) ? -sq : sq;
                        pend_hi_d = bus.a[31] ? -sr : sr;
                    end
                    default: {pend_hi_d, pend_lo_d} = {ur, uq};
                endcase
            end
            if (bus.start && bus.mdu_op == 4'd5) hi_d = bus.a;
            if (bus.start && bus.mdu_op == 4'd6) lo_d = bus.a;
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                hi_d    = pend_v_q ? pend_hi_q : hi_q;
                lo_d    = pend_v_q ? pend_lo_q : lo_q;
            end
        end
    end

    always_comb begin
        bus.busy    = state_q == RUN;
        bus.hi      = hi_q;
        bus.lo      = lo_q;
        bus.mdu_out = (bus.mdu_op == 4'd7) ? hi_q : (bus.mdu_op == 4'd8) ? lo_q : 32'd0;
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors with hand-computed HI/LO and busy lengths
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    int   n;

    e_mdu_if bus ();
    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.a      = av;
        bus.b      = bv;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int c;
        issue(op, av, bv);
        count_busy(c);
        check({tag, " busy"}, 32'(c), 32'(cyc));
        check({tag, " hi"}, bus.hi, ehi);
        check({tag, " lo"}, bus.lo, elo);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        bus.a      = '0;
        bus.b      = '0;
        #12;
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(4'd5, 32'h12345678, 32'd0);
        check("mthi hi", bus.hi, 32'h12345678);
        check("mthi busy", 32'(bus.busy), 32'd0);
        issue(4'd6, 32'hCAFEF00D, 32'd0);
        check("mtlo lo", bus.lo, 32'hCAFEF00D);
        check("mtlo hi kept", bus.hi, 32'h12345678);
        bus.mdu_op = 4'd7;
        #1 check("mfhi", bus.mdu_out, 32'h12345678);
        bus.mdu_op = 4'd8;
        #1 check("mflo", bus.mdu_out, 32'hCAFEF00D);
        bus.mdu_op = 4'd0;
        #1 check("none out", bus.mdu_out, 32'd0);

        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        run_op("div mix", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

        issue(4'd5, 32'hAA, 32'd0);
        issue(4'd6, 32'hBB, 32'd0);
        run_op("divu0", 4'd4, 32'd5, 32'd0, 10, 32'hAA, 32'hBB);
        run_op("div0", 4'd3, 32'd9, 32'd0, 10, 32'hAA, 32'hBB);

        // second start lands on busy cycle 2 and must be dropped
        issue(4'd1, 32'd2, 32'd3);
        issue(4'd3, 32'd100, 32'd10);
        count_busy(n);
        check("ign busy left", 32'(n), 32'd4);
        check("ign hi", bus.hi, 32'd0);
        check("ign lo", bus.lo, 32'd6);
        repeat (12) @(posedge clk);
        #1 check("ign no late", bus.lo, 32'd6);
        check("ign idle", 32'(bus.busy), 32'd0);

        issue(4'd3, 32'd100, 32'd10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid busy before", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid rst busy", 32'(bus.busy), 32'd0);
        check("mid rst hi", bus.hi, 32'd0);
        check("mid rst lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post rst lo", bus.lo, 32'd0);
        check("post rst hi", bus.hi, 32'd0);
        check("post rst busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage, alongside the ALU.
- Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo against architectural HI/LO registers.
- Multi-cycle operation is exposed through a busy flag. The hazard unit stalls D while any MDU instruction is in D and either start or busy is high.
- Operands come from the forwarded E-stage rs/rt values. The read result goes to E forwarding and the M pipeline register like the ALU result.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low (reset==0 clears all state immediately).
- start  in  1  E-stage instruction is a valid MDU instruction this cycle; held 0 when E is flushed.
- mdu_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 behave as none.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- busy  out  1  multi-cycle operation in progress.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- mdu_out  out  32  mfhi→hi, mflo→lo, otherwise 0; combinational from current registers and mdu_op.

Behaviour:
- Reset (async, reset==0): hi=0, lo=0, busy=0, counter=0, pending result=0. Reset mid-operation abandons the operation; HI/LO stay 0 after release.
- State: IDLE (busy=0) and RUN (busy=1). A counter holds the remaining cycles; pending_hi/pending_lo hold the precomputed result.
- IDLE, rising edge with start=1, mdu_op in {1..4}:
  - Compute the result from a and b and latch it into pending.
  - counter ← MULT_CYCLES for ops 1-2, DIV_CYCLES for ops 3-4.
  - busy ← 1.
- RUN, each rising edge:
  - counter ← counter-1.
  - When counter==1: hi ← pending_hi, lo ← pending_lo, busy ← 0 on that edge.
  - Result: busy is high for exactly N cycles after the start edge. HI/LO are visible on the first cycle busy=0.
- mthi/mtlo (IDLE, start=1): hi ← a (op 5) or lo ← a (op 6) at the edge; no busy.
- mfhi/mflo: pure combinational read via mdu_out; no state change. Reads while busy=1 return the old HI/LO; the hazard unit prevents this.
- Any start while busy=1 is ignored (no state change). The hazard unit guarantees this never occurs; the bench checks the ignore.
- Arithmetic:
  - mult: signed 32×32 → 64, hi=[63:32], lo=[31:0].
  - multu: the same, unsigned.
  - div: lo=signed quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (b==0, ops 3/4): busy sequence runs normally; HI/LO are left unchanged at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Parameter value 1: busy high for one cycle; completion on the next edge.
- E flush (E register cleared by stall) only zeroes start. It never cancels an operation already in RUN.

Test Plan:
- Reset and mthi/mtlo: reset low mid-sequence → hi=lo=0, busy=0 immediately. mthi a=0x12345678 → hi=0x12345678 next edge, busy stays 0, mfhi mdu_out=0x12345678.
- Mult: mult a=0xFFFFFFFE(-2), b=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu → hi=0x00000002, lo=0xFFFFFFFA.
- Div: div a=-7(0xFFFFFFF9), b=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- Boundaries:
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu b=0 with prior hi=0xAA, lo=0xBB → busy 10 cycles, then hi=0xAA, lo=0xBB unchanged.
- Start while busy: mult 2×3, then on cycle 2 of busy assert start with div 100/10 → ignored; final lo=6, hi=0, busy drops after cycle 5.
- Reset mid-operation: div started, reset asserted on busy cycle 4 → busy=0, hi=lo=0 at once. After release, no late writeback ever occurs.
